// File: rtl/ov7725_dvp_tx.sv
// OV7725-style DVP transmitter: turns RGB565 pixels from a FIFO into a
// vsync/href/8-bit byte stream with parameterised frame and line timing.
// Pixels go out high byte first, two byte clocks per pixel.
module ov7725_dvp_tx #(
  parameter int unsigned H_PIXEL     = 640,
  parameter int unsigned V_LINE      = 480,
  parameter int unsigned H_BLANK     = 144,
  parameter int unsigned VSYNC_LINES = 3,
  parameter int unsigned V_BACK      = 17,
  parameter int unsigned V_FRONT     = 10
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        tx_en,
  input  logic [15:0] pix_data,
  input  logic        pix_empty,
  output logic        pix_rd_en,
  output logic        ov7725_vsync,
  output logic        ov7725_href,
  output logic [7:0]  ov7725_data,
  output logic        frame_done,
  output logic        underflow
);

  localparam int unsigned LineLen = 2 * H_PIXEL + H_BLANK;
  localparam int unsigned HW      = (LineLen > 2) ? $clog2(LineLen) : 1;
  localparam int unsigned VMaxA   = (VSYNC_LINES > V_BACK) ? VSYNC_LINES : V_BACK;
  localparam int unsigned VMaxB   = (V_LINE > V_FRONT) ? V_LINE : V_FRONT;
  localparam int unsigned VMax    = (VMaxA > VMaxB) ? VMaxA : VMaxB;
  localparam int unsigned VW      = (VMax > 2) ? $clog2(VMax) : 1;

  localparam logic [HW-1:0] HLast   = HW'(LineLen - 1);
  localparam logic [HW-1:0] HActEnd = HW'(2 * H_PIXEL);
  // In-line reads sit on odd h_cnt below this bound (pixels 1..H_PIXEL-1).
  localparam logic [HW-1:0] HRdEnd  = HW'(2 * H_PIXEL - 1);

  localparam logic [VW-1:0] VsyncTop = VW'(VSYNC_LINES - 1);
  localparam logic [VW-1:0] VbackTop = VW'(V_BACK - 1);
  localparam logic [VW-1:0] VactTop  = VW'(V_LINE - 1);
  localparam logic [VW-1:0] VfrontTop = VW'(V_FRONT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StVsync,
    StVback,
    StActive,
    StVfront
  } state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   h_cnt_q, h_cnt_d;
  logic [VW-1:0]   v_cnt_q, v_cnt_d;
  logic [VW-1:0]   v_top;
  logic            h_wrap;

  logic            vsync_d, href_d, rd_en_d, frame_done_d, underflow_d;
  logic [7:0]      data_d;
  logic [7:0]      lo_q, lo_d;
  logic            rd_dly_q, empty_dly_q;

  // Frame sequencer: h_cnt runs per line, v_cnt counts lines within a state.
  always_comb begin
    state_d = state_q;
    h_cnt_d = h_cnt_q;
    v_cnt_d = v_cnt_q;
    h_wrap  = (h_cnt_q == HLast);
    unique case (state_q)
      StVsync:  v_top = VsyncTop;
      StVback:  v_top = VbackTop;
      StActive: v_top = VactTop;
      StVfront: v_top = VfrontTop;
      default:  v_top = '0;
    endcase

    if (state_q == StIdle) begin
      h_cnt_d = '0;
      v_cnt_d = '0;
      if (tx_en) begin
        state_d = StVsync;
      end
    end else begin
      h_cnt_d = h_wrap ? '0 : h_cnt_q + HW'(1);
      if (h_wrap) begin
        if (v_cnt_q == v_top) begin
          v_cnt_d = '0;
          unique case (state_q)
            StVsync:  state_d = StVback;
            StVback:  state_d = StActive;
            StActive: state_d = StVfront;
            StVfront: state_d = tx_en ? StVsync : StIdle;
            default:  state_d = StIdle;
          endcase
        end else begin
          v_cnt_d = v_cnt_q + VW'(1);
        end
      end
    end
  end

  // Outputs are registered from the next-state view so they line up with the state itself.
  always_comb begin
    vsync_d      = (state_d == StVsync);
    href_d       = (state_d == StActive) && (h_cnt_d != '0) && (h_cnt_d <= HActEnd);
    frame_done_d = (state_d == StVfront) && (v_cnt_d == VfrontTop) && (h_cnt_d == HLast);
    // Pixel 0 of each active line is fetched on the last cycle of the preceding line.
    rd_en_d      = ((state_d == StActive) && h_cnt_d[0] && (h_cnt_d < HRdEnd)) ||
                   ((h_cnt_d == HLast) &&
                    (((state_d == StVback) && (v_cnt_d == VbackTop)) ||
                     ((state_d == StActive) && (v_cnt_d != VactTop))));

    lo_d   = lo_q;
    data_d = 8'h00;
    if (rd_dly_q) begin
      lo_d = empty_dly_q ? 8'h00 : pix_data[7:0];
    end
    if (href_d) begin
      if (rd_dly_q) begin
        data_d = empty_dly_q ? 8'h00 : pix_data[15:8];
      end else begin
        data_d = lo_q;
      end
    end

    if ((state_d == StVsync) && (state_q != StVsync)) begin
      underflow_d = 1'b0;
    end else if (pix_rd_en && pix_empty) begin
      underflow_d = 1'b1;
    end else begin
      underflow_d = underflow;
    end
  end

  // State, counters, read pipeline and output registers.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= StIdle;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      lo_q         <= 8'h00;
      rd_dly_q     <= 1'b0;
      empty_dly_q  <= 1'b0;
      pix_rd_en    <= 1'b0;
      ov7725_vsync <= 1'b0;
      ov7725_href  <= 1'b0;
      ov7725_data  <= 8'h00;
      frame_done   <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      state_q      <= state_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      lo_q         <= lo_d;
      rd_dly_q     <= pix_rd_en;
      empty_dly_q  <= pix_rd_en & pix_empty;
      pix_rd_en    <= rd_en_d;
      ov7725_vsync <= vsync_d;
      ov7725_href  <= href_d;
      ov7725_data  <= data_d;
      frame_done   <= frame_done_d;
      underflow    <= underflow_d;
    end
  end

endmodule

// File: tb/tb_ov7725_dvp_tx.sv
// Bench for ov7725_dvp_tx with a small frame geometry (L=14, 70-cycle frame).
module tb_ov7725_dvp_tx;

  localparam int H = 4, V = 2, HB = 6, VS = 1, VB = 1, VF = 1;
  localparam int L = 2 * H + HB;
  localparam int NL = VS + VB + V + VF;
  localparam int F = NL * L;
  localparam int NP = H * V;
  localparam int FIRST = VS + VB;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        tx_en = 1'b0;
  logic        pix_empty = 1'b0;
  logic [15:0] pix_data = 16'h0000;
  logic        pix_rd_en, ov7725_vsync, ov7725_href, frame_done, underflow;
  logic [7:0]  ov7725_data;

  ov7725_dvp_tx #(
    .H_PIXEL(H), .V_LINE(V), .H_BLANK(HB), .VSYNC_LINES(VS), .V_BACK(VB), .V_FRONT(VF)
  ) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .tx_en(tx_en), .pix_data(pix_data),
    .pix_empty(pix_empty), .pix_rd_en(pix_rd_en), .ov7725_vsync(ov7725_vsync),
    .ov7725_href(ov7725_href), .ov7725_data(ov7725_data), .frame_done(frame_done),
    .underflow(underflow)
  );

  always #5 sys_clk = ~sys_clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] fx[NP] = '{16'hA1B2, 16'hC3D4, 16'hE5F6, 16'h0718,
                          16'h293A, 16'h4B5C, 16'h6D7E, 16'h8F90};
  logic [15:0] src[NP];
  bit          mask[NP];
  logic [15:0] exp_pix[NP];
  int          ptr, slot;
  bit          rd_prev = 1'b0, emp_prev = 1'b0;

  logic        s_vs[F+1], s_hr[F+1], s_rd[F+1], s_fd[F+1], s_uf[F+1];
  logic [7:0]  s_d[F+1];

  typedef struct {
    int         k;
    logic       vs;
    logic       hr;
    logic [7:0] d;
    logic       rd;
    logic       fd;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input int k, input logic [15:0] act,
                     input logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s k=%0d got=%0h want=%0h", nm, k, act, want);
    end
  endtask

  // One clock: FIFO model answers the previous strobe, then outputs are sampled on negedge.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (rd_prev && !emp_prev) begin
      pix_data = (ptr < NP) ? src[ptr] : 16'hDEAD;
      ptr++;
    end else begin
      pix_data = 16'($urandom);
    end
    rd_prev = pix_rd_en;
    if (pix_rd_en) begin
      emp_prev  = (slot < NP) ? mask[slot] : 1'b0;
      pix_empty = emp_prev;
      slot++;
    end else begin
      emp_prev  = 1'b0;
      pix_empty = 1'($urandom_range(0, 1));
    end
    @(negedge sys_clk);
  endtask

  task automatic sample(input int k);
    s_vs[k] = ov7725_vsync;
    s_hr[k] = ov7725_href;
    s_d[k]  = ov7725_data;
    s_rd[k] = pix_rd_en;
    s_fd[k] = frame_done;
    s_uf[k] = underflow;
  endtask

  task automatic wait_vsync(input int max, output int n);
    n = 0;
    while (ov7725_vsync !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    if (ov7725_vsync !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL vsync_timeout k=%0d got=%0b want=1", n, ov7725_vsync);
    end
  endtask

  // mode 0: fixed pixels, only slot eslot empty; mode 1: random pixels and empties.
  task automatic setup(input int mode, input int eslot);
    int p;
    for (int n = 0; n < NP; n++) begin
      src[n]  = (mode == 1) ? 16'($urandom) : fx[n];
      mask[n] = (mode == 1) ? ($urandom_range(0, 3) == 0) : (n == eslot);
    end
    p = 0;
    for (int n = 0; n < NP; n++) begin
      if (mask[n]) begin
        exp_pix[n] = 16'h0000;
      end else begin
        exp_pix[n] = src[p];
        p++;
      end
    end
  endtask

  // Current sample is frame cycle 0 (first vsync cycle).
  task automatic record(input int drop_at, input int stop_at);
    ptr  = 0;
    slot = 0;
    sample(0);
    for (int k = 1; k <= stop_at; k++) begin
      if (k == drop_at) tx_en = 1'b0;
      tick();
      sample(k);
    end
  endtask

  // Reference: derive each output from the frame position by arithmetic.
  task automatic check_model(input string tag);
    int   rdc[NP];
    int   line, h, r, p;
    logic e_vs, e_hr, e_rd, e_uf, e_fd;
    logic [7:0] e_d;
    for (int n = 0; n < NP; n++) begin
      r = n / H;
      p = n % H;
      rdc[n] = (p == 0) ? (FIRST + r) * L - 1 : (FIRST + r) * L + 2 * p - 1;
    end
    for (int k = 0; k < F; k++) begin
      line = k / L;
      h    = k % L;
      r    = line - FIRST;
      e_vs = (line < VS);
      e_hr = (r >= 0) && (r < V) && (h >= 1) && (h <= 2 * H);
      e_d  = 8'h00;
      if (e_hr) begin
        p   = (h - 1) / 2;
        e_d = (((h - 1) % 2) == 0) ? exp_pix[r * H + p][15:8] : exp_pix[r * H + p][7:0];
      end
      e_rd = 1'b0;
      e_uf = 1'b0;
      for (int n = 0; n < NP; n++) begin
        if (rdc[n] == k) e_rd = 1'b1;
        if (mask[n] && rdc[n] < k) e_uf = 1'b1;
      end
      e_fd = (k == F - 1);
      chk({tag, "_vsync"}, k, 16'(s_vs[k]), 16'(e_vs));
      chk({tag, "_href"}, k, 16'(s_hr[k]), 16'(e_hr));
      chk({tag, "_data"}, k, 16'(s_d[k]), 16'(e_d));
      chk({tag, "_rd_en"}, k, 16'(s_rd[k]), 16'(e_rd));
      chk({tag, "_done"}, k, 16'(s_fd[k]), 16'(e_fd));
      chk({tag, "_uflow"}, k, 16'(s_uf[k]), 16'(e_uf));
    end
  endtask

  initial begin
    int n;
    tbl.push_back('{0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{13, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{14, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{27, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{28, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{29, 1'b0, 1'b1, 8'hA1, 1'b1, 1'b0});
    tbl.push_back('{30, 1'b0, 1'b1, 8'hB2, 1'b0, 1'b0});
    tbl.push_back('{31, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b0});
    tbl.push_back('{32, 1'b0, 1'b1, 8'hD4, 1'b0, 1'b0});
    tbl.push_back('{35, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0});
    tbl.push_back('{36, 1'b0, 1'b1, 8'h18, 1'b0, 1'b0});
    tbl.push_back('{37, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{41, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0});
    tbl.push_back('{43, 1'b0, 1'b1, 8'h29, 1'b1, 1'b0});
    tbl.push_back('{50, 1'b0, 1'b1, 8'h90, 1'b0, 1'b0});
    tbl.push_back('{55, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0});
    tbl.push_back('{69, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
    tbl.push_back('{70, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0});

    // Reset state.
    repeat (3) @(negedge sys_clk);
    chk("rst_vsync", 0, 16'(ov7725_vsync), 16'h0);
    chk("rst_href", 0, 16'(ov7725_href), 16'h0);
    chk("rst_data", 0, 16'(ov7725_data), 16'h0);
    chk("rst_rd_en", 0, 16'(pix_rd_en), 16'h0);
    chk("rst_done", 0, 16'(frame_done), 16'h0);
    chk("rst_uflow", 0, 16'(underflow), 16'h0);
    sys_rst = 1'b0;
    repeat (4) tick();
    chk("idle_vsync", 0, 16'(ov7725_vsync), 16'h0);
    chk("idle_rd_en", 0, 16'(pix_rd_en), 16'h0);

    // Fixed pixel frame against the vector table.
    setup(0, -1);
    tx_en = 1'b1;
    wait_vsync(4, n);
    chk("start_latency", 0, 16'(n), 16'd1);
    record(-1, F);
    foreach (tbl[i]) begin
      chk("tbl_vsync", tbl[i].k, 16'(s_vs[tbl[i].k]), 16'(tbl[i].vs));
      chk("tbl_href", tbl[i].k, 16'(s_hr[tbl[i].k]), 16'(tbl[i].hr));
      chk("tbl_data", tbl[i].k, 16'(s_d[tbl[i].k]), 16'(tbl[i].d));
      chk("tbl_rd_en", tbl[i].k, 16'(s_rd[tbl[i].k]), 16'(tbl[i].rd));
      chk("tbl_done", tbl[i].k, 16'(s_fd[tbl[i].k]), 16'(tbl[i].fd));
    end
    check_model("fixed");

    // Back-to-back random frames with random FIFO empties.
    repeat (3) begin
      setup(1, -1);
      record(-1, F);
      check_model("rand");
    end

    // Single empty read on pixel 2 of line 0; flag clears as the next vsync rises.
    setup(0, 2);
    record(-1, F);
    check_model("uflow");
    chk("uflow_d33", 33, 16'(s_d[33]), 16'h00);
    chk("uflow_d34", 34, 16'(s_d[34]), 16'h00);
    chk("uflow_clr", F, 16'(s_uf[F]), 16'h0);
    chk("uflow_next_vs", F, 16'(s_vs[F]), 16'h1);

    // tx_en drops in active line 1: frame completes, then idle.
    setup(1, -1);
    record(45, F);
    check_model("drop");
    chk("drop_no_vs", F, 16'(s_vs[F]), 16'h0);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("idle2_vsync", i, 16'(ov7725_vsync), 16'h0);
      chk("idle2_href", i, 16'(ov7725_href), 16'h0);
      chk("idle2_rd_en", i, 16'(pix_rd_en), 16'h0);
      chk("idle2_data", i, 16'(ov7725_data), 16'h0);
    end
    tx_en = 1'b1;
    tick();
    chk("restart_vsync", 0, 16'(ov7725_vsync), 16'h1);

    // Asynchronous reset in the middle of an href burst.
    setup(0, -1);
    record(-1, 30);
    chk("pre_rst_href", 30, 16'(s_hr[30]), 16'h1);
    chk("pre_rst_data", 30, 16'(s_d[30]), 16'(exp_pix[0][7:0]));
    #2;
    sys_rst = 1'b1;
    #1;
    chk("async_vsync", 0, 16'(ov7725_vsync), 16'h0);
    chk("async_href", 0, 16'(ov7725_href), 16'h0);
    chk("async_data", 0, 16'(ov7725_data), 16'h0);
    chk("async_rd_en", 0, 16'(pix_rd_en), 16'h0);
    tick();
    tick();
    sys_rst = 1'b0;
    wait_vsync(4, n);
    chk("post_rst_latency", 0, 16'(n), 16'd1);
    setup(1, -1);
    record(-1, F);
    check_model("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog k=0 got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
